// File: rtl/vga_pkg.sv
// Shared VGA blockram constants and the frame writer state encoding.
// Also consumed by the blockram instance and the read side.
package vga_pkg;

    localparam int BRAM_ADDR_BITS = 8;
    localparam int BRAM_DATA_BITS = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOW    = 2'd1,
        S_HIGH   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/bram_frame_writer_if.sv
// Byte stream handshake into the frame writer.
// master = byte source, slave = frame writer.
interface bram_frame_writer_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sof;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_sof,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sof,
        output in_ready
    );

endinterface

// File: rtl/bram_frame_writer_packer.sv
// Byte pair assembly with start-of-frame resync.
// Holds the packed word in S_COMMIT until the commit stage takes it.
module byte_pair_packer
    import vga_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RST_N,
    bram_frame_writer_if.slave        s,
    input  logic                      word_ack,
    output logic                      word_valid,
    output logic [BRAM_DATA_BITS-1:0] word,
    output logic                      sof_seen
);

    state_t     state;
    logic [7:0] low;
    logic       take;

    assign s.in_ready  = (state == S_LOW) || (state == S_HIGH);
    assign take        = s.in_valid && s.in_ready;
    assign word_valid  = (state == S_COMMIT);
    assign sof_seen    = take && s.in_sof;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            low   <= '0;
            word  <= '0;
        end else begin
            unique case (state)
                S_IDLE: state <= S_LOW;
                S_LOW: begin
                    if (take) begin
                        low   <= s.in_data;
                        state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    // sof byte replaces any pending low byte
                    if (take && s.in_sof) begin
                        low <= s.in_data;
                    end else if (take) begin
                        word  <= {s.in_data, low};
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (word_ack) state <= S_LOW;
                end
            endcase
        end
    end

endmodule

// File: rtl/bram_frame_writer.sv
// Packs a byte stream into 16-bit words and writes them into the blockram.
// Commits wait for write_allow so loads can avoid the visible range.
module bram_frame_writer
    import vga_pkg::*;
#(
    parameter int ADDR_BITS = BRAM_ADDR_BITS,
    parameter int DATA_BITS = BRAM_DATA_BITS,
    parameter int DEPTH     = 256
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    bram_frame_writer_if.slave   s,
    input  logic                 write_allow,
    output logic                 w_en,
    output logic [ADDR_BITS-1:0] w_addr,
    output logic [DATA_BITS-1:0] w_data,
    output logic                 frame_done,
    output logic [ADDR_BITS:0]   word_count
);

    localparam logic [ADDR_BITS-1:0] LAST     = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS + 1)'(1);

    logic                      word_valid;
    logic [BRAM_DATA_BITS-1:0] word;
    logic                      sof_seen;
    logic                      commit;
    logic                      at_last;
    logic [ADDR_BITS-1:0]      addr;

    byte_pair_packer u_pack (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .s          (s),
        .word_ack   (write_allow),
        .word_valid (word_valid),
        .word       (word),
        .sof_seen   (sof_seen)
    );

    assign commit  = word_valid && write_allow;
    assign at_last = (addr == LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_en       <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            frame_done <= 1'b0;
            word_count <= '0;
            addr       <= '0;
        end else begin
            w_en       <= commit;
            frame_done <= commit && at_last;
            if (sof_seen) begin
                addr       <= '0;
                word_count <= '0;
            end else if (commit) begin
                w_addr <= addr;
                w_data <= word;
                // wrap at DEPTH, never exposing DEPTH on word_count
                if (at_last) begin
                    addr       <= '0;
                    word_count <= '0;
                end else begin
                    addr       <= addr + ADDR_ONE;
                    word_count <= word_count + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_frame_writer.sv
// Scoreboard bench for bram_frame_writer with a small DEPTH to hit wrap.
// Byte-level model feeds a queue; a monitor pops on every w_en.
module tb_bram_frame_writer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        fd;
        logic [8:0]  cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        write_allow;
    logic        w_en;
    logic [7:0]  w_addr;
    logic [15:0] w_data;
    logic        frame_done;
    logic [8:0]  word_count;

    bram_frame_writer_if bus ();

    bram_frame_writer #(
        .ADDR_BITS (8),
        .DATA_BITS (16),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .s           (bus),
        .write_allow (write_allow),
        .w_en        (w_en),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .frame_done  (frame_done),
        .word_count  (word_count)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int         m_addr = 0;
    int         m_cnt  = 0;
    logic [7:0] m_low  = 8'h00;
    bit         m_have = 1'b0;
    bit         rand_on = 1'b0;
    logic       wa_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_cnt  = 0;
        m_have = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [7:0] d, input logic sof);
        exp_t e;
        if (sof) begin
            m_addr = 0;
            m_cnt  = 0;
            m_low  = d;
            m_have = 1'b1;
        end else if (!m_have) begin
            m_low  = d;
            m_have = 1'b1;
        end else begin
            e.addr = 8'(m_addr);
            e.data = {d, m_low};
            e.fd   = (m_addr == DEPTH - 1);
            m_cnt  = e.fd ? 0 : m_cnt + 1;
            e.cnt  = 9'(m_cnt);
            exp_q.push_back(e);
            m_addr = (m_addr + 1) % DEPTH;
            m_have = 1'b0;
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send(input logic [7:0] d, input logic sof);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        while (!done) begin
            #3;
            if (bus.in_ready) begin
                model_accept(d, sof);
                done = 1'b1;
            end
            @(posedge CLK);
            #1;
            n++;
            if (!done && n > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0h not accepted", d);
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge CLK) wa_last <= write_allow;

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (frame_done && !w_en) begin
                checks++;
                errors++;
                $display("FAIL frame_done_alone: got 1 expected 0");
            end
            if (w_en) begin
                checks++;
                if (!wa_last) begin
                    errors++;
                    $display("FAIL gate: w_en got 1 expected 0 (write_allow low)");
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wen: addr %0h data %0h expected none",
                             w_addr, w_data);
                end else begin
                    e = exp_q.pop_front();
                    if (w_addr !== e.addr || w_data !== e.data ||
                        frame_done !== e.fd || word_count !== e.cnt) begin
                        errors++;
                        $display("FAIL write: got a=%0h d=%0h fd=%0b c=%0d expected a=%0h d=%0h fd=%0b c=%0d",
                                 w_addr, w_data, frame_done, word_count,
                                 e.addr, e.data, e.fd, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (rand_on) write_allow = ($urandom_range(0, 9) < 7);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N        = 1'b0;
        write_allow  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_sof   = 1'b0;
        model_reset();

        // reset and idle
        repeat (3) begin
            #3;
            chk("rst_ready", 32'(bus.in_ready), 32'd0);
            @(posedge CLK);
            #1;
        end
        chk("rst_wen", 32'(w_en), 32'd0);
        chk("rst_waddr", 32'(w_addr), 32'd0);
        chk("rst_wdata", 32'(w_data), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_cnt", 32'(word_count), 32'd0);
        RST_N = 1'b1;
        #3;
        chk("idle_ready", 32'(bus.in_ready), 32'd0);
        @(posedge CLK);
        #3;
        chk("low_ready", 32'(bus.in_ready), 32'd1);
        @(posedge CLK);
        #1;

        // single word with latency
        write_allow = 1'b1;
        send(8'h34, 1'b0);
        send(8'h12, 1'b0);
        chk("lat_early", 32'(w_en), 32'd0);
        @(posedge CLK);
        #3;
        chk("lat_wen", 32'(w_en), 32'd1);
        chk("single_data", 32'(w_data), 32'h1234);
        chk("single_cnt", 32'(word_count), 32'd1);
        @(posedge CLK);
        #1;
        drain();

        // gated commit
        write_allow = 1'b0;
        send(8'hCD, 1'b0);
        send(8'hAB, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        repeat (20) begin
            #3;
            chk("gate_ready", 32'(bus.in_ready), 32'd0);
            chk("gate_wen", 32'(w_en), 32'd0);
            @(posedge CLK);
            #1;
        end
        bus.in_valid = 1'b0;
        write_allow  = 1'b1;
        @(posedge CLK);
        #3;
        chk("gate_release", 32'(w_en), 32'd1);
        chk("gate_data", 32'(w_data), 32'hABCD);
        @(posedge CLK);
        #1;
        drain();

        // frame wrap, then next frame at addr 0
        send(8'h00, 1'b1);
        for (int i = 1; i < 10; i++) send(8'(i), 1'b0);
        drain();

        // mid-pair sof
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        send(8'h33, 1'b0);
        drain();
        chk("sof_cnt", 32'(word_count), 32'd1);
        chk("sof_addr", 32'(w_addr), 32'd0);

        // async reset mid-commit
        write_allow = 1'b0;
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        @(posedge CLK);
        #1;
        write_allow = 1'b1;
        RST_N       = 1'b0;
        model_reset();
        #1;
        chk("arst_wen", 32'(w_en), 32'd0);
        chk("arst_waddr", 32'(w_addr), 32'd0);
        chk("arst_cnt", 32'(word_count), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd0);
        @(posedge CLK);
        #3;
        chk("arst_wen_hold", 32'(w_en), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        drain();
        chk("arst_new_data", 32'(w_data), 32'h8877);

        // randomized traffic
        rand_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK);
                #1;
            end
            send(8'($urandom), ($urandom_range(0, 15) == 0));
        end
        rand_on = 1'b0;
        write_allow = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_frame_writer.md
Name: bram_frame_writer

Overview:
- Write-side companion to the VGA blockram read path: accepts a byte stream (valid/ready), packs byte pairs into 16-bit words and writes them sequentially into the implicit blockram write port (w_en / w_addr / data_in).
- Writes are committed only while `write_allow` is high, so the frame loader can hold off during the visible range and avoid tearing.
- Sits between a byte source (UART RX or SPI loader) and the blockram instance in the VGA top level.

Parameters:
- ADDR_BITS, 8, blockram address width.
- DATA_BITS, 16, blockram word width; fixed at 2 × 8-bit bytes.
- DEPTH, 256, number of words per frame; must be ≤ 2**ADDR_BITS.

Ports:
- CLK  in  1  system clock (12 MHz).
- RST_N  in  1  asynchronous active-low reset.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  8  byte value.
- in_sof  in  1  start-of-frame marker, qualified by in_valid && in_ready.
- in_ready  out  1  block accepts a byte this cycle.
- write_allow  in  1  commit permitted this cycle (e.g. ~visible_range).
- w_en  out  1  blockram write enable, one-cycle pulse.
- w_addr  out  ADDR_BITS  blockram write address.
- w_data  out  DATA_BITS  blockram write data.
- frame_done  out  1  one-cycle pulse after the word at DEPTH-1 is written.
- word_count  out  ADDR_BITS+1  words written in the current frame.

Behaviour:
- Reset (RST_N low, async): state = S_IDLE; w_en 0, w_addr 0, w_data 0, frame_done 0, word_count 0, internal addr 0, low-byte register 0. in_ready is 0 throughout reset.
- A byte is accepted when in_valid && in_ready on a CLK rising edge.
- in_ready = 1 only in S_LOW and S_HIGH; it is a combinational decode of the state register.
- FSM transitions:
  - S_IDLE -> S_LOW on the first clock after reset release.
  - S_LOW: on an accepted byte, latch it as the low byte, -> S_HIGH.
  - S_HIGH: on an accepted byte without in_sof, form word = {byte, low}, -> S_COMMIT.
  - S_COMMIT: in_ready 0. When write_allow is 1: register w_en 1, w_addr = addr, w_data = word, addr++, word_count++, -> S_LOW. When write_allow is 0, hold indefinitely with no data loss.
- Latency: w_en is asserted the cycle after S_COMMIT samples write_allow = 1. Minimum accepted-high-byte to w_en is 2 cycles.
- w_en, frame_done: high for exactly one cycle per event. w_addr and w_data hold their last values when w_en is 0.
- Start of frame: an accepted byte with in_sof = 1, in S_LOW or S_HIGH:
  - addr = 0, word_count = 0;
  - any pending low byte is discarded;
  - the sof byte is taken as the new low byte, -> S_HIGH.
- in_sof has no effect in S_COMMIT (in_ready is 0 there).
- Wrap: committing addr = DEPTH-1 pulses frame_done with the same cycle timing as w_en, then sets addr = 0 and word_count = 0.
  - In that cycle word_count never shows DEPTH; it goes DEPTH-1 -> 0.
  - Further bytes start the next frame at addr 0.
- in_valid deasserting mid-pair keeps the state; there is no timeout.
- RST_N asserted mid-operation: immediate return to reset values. A write in flight is dropped (w_en forced to 0 asynchronously).
- Arithmetic: addr is ADDR_BITS wide and compared against DEPTH-1. With DEPTH < 2**ADDR_BITS, the block wraps at DEPTH, not at 2**ADDR_BITS.

Decomposition:
- Shared package `vga_pkg`:
  - state encoding constants S_IDLE, S_LOW, S_HIGH, S_COMMIT (2 bits);
  - BRAM_ADDR_BITS = 8, BRAM_DATA_BITS = 16 (also used by the blockram and the read side).
- One natural sub-module, `byte_pair_packer`: S_LOW/S_HIGH assembly plus sof handling, producing a word_valid/word handshake.
- The top holds the commit stage, the address counter and frame_done.

Test Plan:
- Reset then idle: RST_N low 3 cycles, then release -> in_ready 0 during reset and 1 from the second cycle after release; all outputs 0.
- Single word: write_allow = 1; send 0x34 then 0x12 -> exactly one w_en pulse with w_addr 0x00, w_data 0x1234, 2 cycles after the second byte; word_count 1.
- Gated commit: write_allow = 0; send 0xCD, 0xAB -> in_ready 0 and no w_en for 20 cycles. Raise write_allow -> w_en with w_data 0xABCD next cycle; extra bytes presented meanwhile are not accepted.
- Frame wrap: DEPTH = 4; send 8 bytes 0x00..0x07 -> writes at addr 0..3 with data 0x0100, 0x0302, 0x0504, 0x0706; frame_done pulses with the addr-3 write; the next pair writes addr 0.
- Mid-pair sof: send 0x11, then 0x22 with in_sof, then 0x33 -> one write of 0x3322 at addr 0; 0x11 is discarded; word_count 1.
- Async reset mid-commit: drop RST_N in S_COMMIT, coincident with a write_allow rising edge -> w_en stays 0, w_addr 0, state S_IDLE; after release a new pair writes at addr 0.
